// File: rtl/conv_window_gen.sv
// Streaming KxK sliding-window generator: raster-order pixels in, strided valid-convolution windows out.
// K-1 line buffers feed a KxK shift array; a ready/valid handshake back-pressures the pixel stream.
module conv_window_gen #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int STRIDE = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     new_image,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     win_valid,
    input  logic                     out_ready,
    output logic [K*K*DATA_W-1:0]    win_data,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
    output logic                     frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    if (K < 1 || STRIDE < 1 || K > IMG_W || K > IMG_H) begin : g_param_check
        $error("conv_window_gen: need K>=1, STRIDE>=1, K<=IMG_W and K<=IMG_H");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t        state_q;
    logic [CW-1:0] col_q, ocol_q, win_col_q;
    logic [RW-1:0] row_q, orow_q, win_row_q;
    logic [PW-1:0] cph_q, rph_q;
    logic          win_valid_q, frame_done_q;

    logic accept, col_hit, row_hit, col_last, row_last;

    // cph_q/rph_q track (pos-K+1) % STRIDE once pos >= K-1, avoiding a runtime modulo/divide.
    function automatic logic [PW-1:0] ph_next(input logic [PW-1:0] ph);
        return (ph == PW'(STRIDE - 1)) ? '0 : ph + 1'b1;
    endfunction

    assign in_ready   = (state_q == S_RUN) && (!win_valid_q || out_ready);
    assign accept     = in_valid && in_ready && !new_image;
    assign col_hit    = (col_q >= CW'(K - 1)) && (cph_q == '0);
    assign row_hit    = (row_q >= RW'(K - 1)) && (rph_q == '0);
    assign col_last   = (col_q == CW'(IMG_W - 1));
    assign row_last   = (row_q == RW'(IMG_H - 1));

    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = frame_done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            cph_q        <= '0;
            rph_q        <= '0;
            ocol_q       <= '0;
            orow_q       <= '0;
            win_col_q    <= '0;
            win_row_q    <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (new_image) begin
                state_q     <= S_RUN;
                col_q       <= '0;
                row_q       <= '0;
                cph_q       <= '0;
                rph_q       <= '0;
                ocol_q      <= '0;
                orow_q      <= '0;
                win_valid_q <= 1'b0;
            end else begin
                if (win_valid_q && out_ready)
                    win_valid_q <= 1'b0;
                if (accept) begin
                    if (col_hit && row_hit) begin
                        win_valid_q <= 1'b1;
                        win_row_q   <= orow_q;
                        win_col_q   <= ocol_q;
                    end
                    if (col_last) begin
                        col_q  <= '0;
                        cph_q  <= '0;
                        ocol_q <= '0;
                        if (row_last) begin
                            row_q   <= '0;
                            rph_q   <= '0;
                            orow_q  <= '0;
                            state_q <= S_DRAIN;
                        end else begin
                            row_q <= row_q + 1'b1;
                            if (row_q >= RW'(K - 1))
                                rph_q <= ph_next(rph_q);
                            if (row_hit)
                                orow_q <= orow_q + 1'b1;
                        end
                    end else begin
                        col_q <= col_q + 1'b1;
                        if (col_q >= CW'(K - 1))
                            cph_q <= ph_next(cph_q);
                        if (col_hit)
                            ocol_q <= ocol_q + 1'b1;
                    end
                end
                if (state_q == S_DRAIN && !(win_valid_q && !out_ready)) begin
                    state_q      <= S_IDLE;
                    frame_done_q <= 1'b1;
                end
            end
        end
    end

    // tap[i] is the pixel at the current column from i rows above the incoming one.
    logic [DATA_W-1:0] tap [K];
    assign tap[0] = in_data;

    for (genvar i = 1; i < K; i++) begin : g_lb
        logic [DATA_W-1:0] mem [IMG_W];
        assign tap[i] = mem[col_q];
        always_ff @(posedge clk) begin
            if (accept)
                mem[col_q] <= tap[i-1];
        end
    end

    logic [DATA_W-1:0] win_q [K][K];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    win_q[r][c] <= '0;
        end else if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++)
                    win_q[r][c] <= win_q[r][c+1];
                win_q[r][K-1] <= tap[K-1-r];
            end
        end
    end

    for (genvar r = 0; r < K; r++) begin : g_wr
        for (genvar c = 0; c < K; c++) begin : g_wc
            assign win_data[(r*K+c)*DATA_W +: DATA_W] = win_q[r][c];
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: a pixel-array reference model predicts every window, handshake and pulse;
// a STRIDE=1 companion instance shadows the accepted pixel stream.
module tb_conv_window_gen;
    localparam int DW   = 16;
    localparam int IW   = 8;
    localparam int IH   = 8;
    localparam int KK   = 3;
    localparam int S    = 2;
    localparam int WW   = KK*KK*DW;
    localparam int NPIX = IW*IH;
    localparam int OW   = (IW-KK)/S+1;
    localparam int OH   = (IH-KK)/S+1;

    logic clk = 1'b0, reset = 1'b1, new_image = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic in_ready, win_valid, frame_done;
    logic [WW-1:0] win_data;
    logic [$clog2(IH)-1:0] win_row;
    logic [$clog2(IW)-1:0] win_col;

    logic in_valid1, in_ready1, win_valid1, frame_done1;
    logic out_ready1 = 1'b1;
    logic [WW-1:0] win_data1;
    logic [$clog2(IH)-1:0] win_row1;
    logic [$clog2(IW)-1:0] win_col1;
    assign in_valid1 = in_valid && in_ready;

    conv_window_gen #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .K(KK), .STRIDE(S)) dut (
        .clk(clk), .reset(reset), .new_image(new_image), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .win_valid(win_valid), .out_ready(out_ready), .win_data(win_data),
        .win_row(win_row), .win_col(win_col), .frame_done(frame_done));

    conv_window_gen #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .K(KK), .STRIDE(1)) dut1 (
        .clk(clk), .reset(reset), .new_image(new_image), .in_valid(in_valid1), .in_data(in_data),
        .in_ready(in_ready1), .win_valid(win_valid1), .out_ready(out_ready1), .win_data(win_data1),
        .win_row(win_row1), .win_col(win_col1), .frame_done(frame_done1));

    always #5 clk = ~clk;

    typedef struct { logic [WW-1:0] d; int r; int c; } win_t;

    int nchk = 0, nerr = 0;
    bit m_run, m_drain, exp_wv, exp_fd;
    int acc_cnt, frame_wins, fd_total, fd1_total, cnt1;
    logic [DW-1:0] img [NPIX];
    win_t q[$];
    logic [WW-1:0] cap00, cap22, cap01;
    int rdy_mode = 0, stall_left = 0;
    bit stall_done;
    int e00[KK*KK] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    int e22[KK*KK] = '{36, 37, 38, 44, 45, 46, 52, 53, 54};
    int e01[KK*KK] = '{1, 2, 3, 9, 10, 11, 17, 18, 19};

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WW-1:0] pack(input int v[KK*KK]);
        logic [WW-1:0] p;
        p = '0;
        for (int i = 0; i < KK*KK; i++) p[i*DW +: DW] = DW'(v[i]);
        return p;
    endfunction

    task automatic clear_model();
        exp_wv = 0; acc_cnt = 0; frame_wins = 0; q.delete();
        cap00 = '0; cap22 = '0;
    endtask

    // One model step per negedge: check current outputs, then advance on the upcoming edge's inputs.
    task automatic mon_step();
        bit exp_ir, acc;
        int idx, r, c;
        win_t w;
        if (reset) begin
            chk("rst_win_valid", WW'(win_valid), '0);
            chk("rst_in_ready", WW'(in_ready), '0);
            chk("rst_frame_done", WW'(frame_done), '0);
            chk("rst_win_data", win_data, '0);
            m_run = 0; m_drain = 0; exp_fd = 0;
            clear_model();
            return;
        end
        exp_ir = m_run && (!exp_wv || out_ready);
        chk("win_valid", WW'(win_valid), WW'(exp_wv));
        chk("in_ready", WW'(in_ready), WW'(exp_ir));
        chk("frame_done", WW'(frame_done), WW'(exp_fd));
        if (frame_done) fd_total++;
        if (win_valid1) begin
            cnt1++;
            if (win_row1 == 0 && win_col1 == 1) cap01 = win_data1;
        end
        if (frame_done1) fd1_total++;
        if (win_valid) begin
            if (q.size() == 0) chk("win_unexpected", WW'(win_valid), '0);
            else begin
                chk("win_data", win_data, q[0].d);
                chk("win_row", WW'(win_row), WW'(q[0].r));
                chk("win_col", WW'(win_col), WW'(q[0].c));
                if (out_ready) begin
                    if (q[0].r == 0 && q[0].c == 0) cap00 = win_data;
                    if (q[0].r == 2 && q[0].c == 2) cap22 = win_data;
                    void'(q.pop_front());
                    frame_wins++;
                end
            end
        end
        acc = in_valid && exp_ir && !new_image;
        exp_fd = 0;
        if (new_image) begin
            m_run = 1; m_drain = 0;
            clear_model();
        end else begin
            if (m_drain && !(exp_wv && !out_ready)) begin exp_fd = 1; m_drain = 0; end
            if (exp_wv && out_ready) exp_wv = 0;
            if (acc) begin
                idx = acc_cnt; r = idx / IW; c = idx % IW;
                img[idx] = in_data;
                if (r >= KK-1 && c >= KK-1 && (r-KK+1) % S == 0 && (c-KK+1) % S == 0) begin
                    w.d = '0; w.r = (r-KK+1)/S; w.c = (c-KK+1)/S;
                    for (int rr = 0; rr < KK; rr++)
                        for (int cc = 0; cc < KK; cc++)
                            w.d[(rr*KK+cc)*DW +: DW] = img[(w.r*S+rr)*IW + w.c*S+cc];
                    q.push_back(w);
                    exp_wv = 1;
                end
                acc_cnt++;
                if (idx == NPIX-1) begin m_run = 0; m_drain = 1; end
            end
        end
    endtask

    task automatic pulse_new(input bit with_pixel);
        new_image = 1; in_valid = with_pixel; in_data = 16'd99;
        @(posedge clk); #1;
        new_image = 0; in_valid = 0;
    endtask

    task automatic send(input int n, input int base, input int gap_pct);
        bit took;
        int guard;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                in_valid = 0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            in_valid = 1; in_data = DW'(base + i);
            took = 0; guard = 0;
            while (!took && guard < 200) begin
                @(negedge clk); took = in_ready;
                @(posedge clk); #1;
                guard++;
            end
            chk("accept_timeout", WW'(took), WW'(1));
        end
        in_valid = 0;
    endtask

    task automatic wait_done(input string tag);
        int b, g;
        b = fd_total; g = 0;
        while (fd_total == b && g < 100) begin @(posedge clk); #1; g++; end
        repeat (5) @(posedge clk);
        #1;
        chk({tag, "_frame_done_count"}, WW'(fd_total - b), WW'(1));
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_nwin"}, WW'(frame_wins), WW'(OW*OH));
        chk({tag, "_win00"}, cap00, pack(e00));
        chk({tag, "_win22"}, cap22, pack(e22));
    endtask

    initial begin
        int c1b, f1b;
        fork
            forever begin @(negedge clk); mon_step(); end
            forever begin
                @(posedge clk); #1;
                if (rdy_mode == 1) out_ready = ($urandom_range(0, 1) == 1);
                else if (rdy_mode == 2) begin
                    if (stall_left > 0) begin out_ready = 0; stall_left--; end
                    else if (win_valid && !stall_done) begin
                        out_ready = 0; stall_left = 4; stall_done = 1;
                    end else out_ready = 1;
                end else out_ready = 1;
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("reset_win_valid", WW'(win_valid), '0);
        chk("reset_win_row", WW'(win_row), '0);
        chk("reset_win_col", WW'(win_col), '0);
        reset = 0;

        // No acceptance before the first new_image.
        in_valid = 1; in_data = 16'd5;
        repeat (4) begin @(negedge clk); chk("idle_in_ready", WW'(in_ready), '0); end
        @(posedge clk); #1;
        in_valid = 0;

        // Back-to-back frame, both strides.
        c1b = cnt1; f1b = fd1_total;
        pulse_new(0);
        send(NPIX, 0, 0);
        wait_done("t1");
        check_frame("t1");
        chk("s1_nwin", WW'(cnt1 - c1b), WW'(36));
        chk("s1_win01", cap01, pack(e01));
        chk("s1_frame_done_count", WW'(fd1_total - f1b), WW'(1));

        // Consumer stalls 5 cycles at the first window.
        rdy_mode = 2; stall_done = 0;
        pulse_new(0);
        send(NPIX, 0, 0);
        wait_done("t2");
        check_frame("t2");

        // Random input gaps, then random back-pressure on top.
        rdy_mode = 0;
        pulse_new(0);
        send(NPIX, 0, 50);
        wait_done("t3");
        check_frame("t3");
        rdy_mode = 1;
        pulse_new(0);
        send(NPIX, 0, 30);
        wait_done("t3r");
        check_frame("t3r");
        rdy_mode = 0;

        // Abort after 30 pixels; the restart pulse carries a pixel that must be dropped.
        pulse_new(0);
        send(30, 0, 0);
        pulse_new(1);
        send(NPIX, 0, 0);
        wait_done("t4");
        check_frame("t4");

        // Asynchronous reset mid-frame.
        pulse_new(0);
        send(20, 100, 0);
        #2 reset = 1;
        #1;
        chk("arst_win_valid", WW'(win_valid), '0);
        chk("arst_in_ready", WW'(in_ready), '0);
        chk("arst_frame_done", WW'(frame_done), '0);
        chk("arst_win_row", WW'(win_row), '0);
        chk("arst_win_col", WW'(win_col), '0);
        chk("arst_win_data", win_data, '0);
        @(posedge clk); #2 reset = 0;
        @(posedge clk); #1;
        in_valid = 1;
        repeat (4) begin @(negedge clk); chk("post_rst_in_ready", WW'(in_ready), '0); end
        @(posedge clk); #1;
        in_valid = 0;
        pulse_new(0);
        send(NPIX, 0, 0);
        wait_done("t5");
        check_frame("t5");

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, pixel width in bits.
REQ-002 The block SHALL have parameter IMG_W, default 8, image width in pixels.
REQ-003 The block SHALL have parameter IMG_H, default 8, image height in pixels.
REQ-004 The block SHALL have parameter K, default 3, square window size.
REQ-005 The block SHALL have parameter STRIDE, default 2, window step in both axes.
REQ-006 Elaboration SHALL fail unless K>=1, STRIDE>=1, K<=IMG_W and K<=IMG_H.
REQ-007 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-008 Port reset  input  1  is asynchronous, active-high reset.
REQ-009 Port new_image  input  1  is a single-cycle frame start/restart pulse.
REQ-010 Port in_valid  input  1  means in_data carries a valid pixel.
REQ-011 Port in_data  input  DATA_W  is the pixel, raster order, row-major.
REQ-012 Port in_ready  output  1  means the block accepts a pixel this cycle.
REQ-013 Port win_valid  output  1  means the window output is valid.
REQ-014 Port out_ready  input  1  means the consumer accepts the window.
REQ-015 Port win_data  output  K*K*DATA_W  is the window; element (r,c) at [(r*K+c)*DATA_W +: DATA_W], r=0 top row, c=0 left column.
REQ-016 Port win_row  output  $clog2(IMG_H)  is the output-map row index of the window.
REQ-017 Port win_col  output  $clog2(IMG_W)  is the output-map column index of the window.
REQ-018 Port frame_done  output  1  is a one-cycle pulse after the last window of a frame.

Function
REQ-019 Output map size SHALL be OUT_W=(IMG_W-K)/STRIDE+1 by OUT_H=(IMG_H-K)/STRIDE+1; valid (no padding) convolution only.
REQ-020 FSM states SHALL be IDLE, RUN and DRAIN.
REQ-021 IDLE->RUN on new_image; RUN->DRAIN on acceptance of pixel (IMG_H-1, IMG_W-1); DRAIN->IDLE when no window is pending, with frame_done high for exactly that transition cycle.
REQ-022 in_ready SHALL equal (state==RUN) && (!win_valid || out_ready) and SHALL not depend combinationally on in_valid or new_image.
REQ-023 A pixel is accepted iff in_valid && in_ready && !new_image; on acceptance the column counter increments, wrapping to 0 at IMG_W-1 with row increment.
REQ-024 K-1 line buffers of IMG_W entries SHALL hold the previous K-1 rows; the window SHALL be a KxK shift-register array fed with the accepted pixel and line-buffer outputs at the same column.
REQ-025 A window SHALL be emitted when accepted pixel (row,col) satisfies row>=K-1, col>=K-1, (row-K+1)%STRIDE==0 and (col-K+1)%STRIDE==0.
REQ-026 win_valid SHALL rise the cycle after the qualifying acceptance (latency 1), with win_row=(row-K+1)/STRIDE and win_col=(col-K+1)/STRIDE.
REQ-027 While win_valid && !out_ready, win_data, win_row and win_col SHALL hold stable and no pixel SHALL be accepted.
REQ-028 A window handshake (win_valid && out_ready) without a new qualifying acceptance in the same cycle SHALL clear win_valid next cycle; with one, win_valid SHALL stay high with the new window.
REQ-029 Columns left of K-1 SHALL never produce windows, so row wrap-around contents are never emitted.
REQ-030 new_image in RUN or DRAIN SHALL abort the frame: counters to 0, win_valid cleared, state RUN next cycle, no frame_done; line-buffer contents need not be cleared.
REQ-031 new_image in RUN, in the same cycle as in_valid, SHALL discard that pixel.
REQ-032 Gaps in in_valid SHALL not alter results; latency counts from the acceptance cycle.

Reset
REQ-033 reset SHALL force, asynchronously, state=IDLE, counters=0, in_ready=0, win_valid=0, frame_done=0, win_row=0, win_col=0, win_data=0.
REQ-034 Line-buffer storage SHALL not require reset.
REQ-035 After reset deasserts, no pixel SHALL be accepted before new_image.

Verification
REQ-036 Defaults, new_image, pixels 0..63 back-to-back, out_ready=1 -> 9 windows; first at win_row=0,win_col=0 = {0,1,2,8,9,10,16,17,18}; last at (2,2) = {36,37,38,44,45,46,52,53,54}; one frame_done pulse.
REQ-037 As REQ-036 with out_ready low 5 cycles at first window -> win_data held, in_ready=0 for those cycles, identical 9 windows.
REQ-038 STRIDE=1, same stimulus -> 36 windows; window (0,1) = {1,2,3,9,10,11,17,18,19}.
REQ-039 Random in_valid gaps (50%) -> windows identical to REQ-036.
REQ-040 new_image after 30 pixels, then 64 pixels from 0 -> no frame_done for aborted frame; 9 windows identical to REQ-036.
REQ-041 reset asserted mid-frame, asynchronously to clk -> all outputs 0 immediately; in_ready stays 0 until new_image.
